pm_serial_loader: RTL and testbench

PM_SERIAL_LOADER -- requirements
Module: pm_serial_loader

---
 rtl/pm_serial_loader.sv | 183 ++++++++++++++++++
 tb/tb_pm_serial_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : pm_serial_loader
// Brief    : Serial program-memory loader with synchronous run-mode fetch port.
//            Optional word parity checking enabled by macro PM_LOADER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 4
`endif
`ifndef INSTR_WORD_WIDTH
`define INSTR_WORD_WIDTH 16
`endif
`ifndef MODE_RUN
`define MODE_RUN 2'b01
`endif
`ifndef MODE_PROG_PM
`define MODE_PROG_PM 2'b10
`endif

module pm_serial_loader #(
  parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = `INSTR_WORD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     load_start,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  output logic                     ser_ready,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     prog_busy,
  output logic                     prog_done,
  output logic [ADDRESS_WIDTH-1:0] word_count,
  output logic                     parity_err
);

  localparam int c_DEPTH = 2 ** ADDRESS_WIDTH;
`ifdef PM_LOADER_PARITY_EN
  localparam int c_BITS  = DATA_WIDTH + 1;
`else
  localparam int c_BITS  = DATA_WIDTH;
`endif
  localparam int c_CNT_W = $clog2(c_BITS + 1);

  localparam logic [1:0] c_MODE_RUN  = `MODE_RUN;
  localparam logic [1:0] c_MODE_PROG = `MODE_PROG_PM;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [c_BITS-1:0]        r_shift;
  logic [c_CNT_W-1:0]       r_bit_cnt;
  logic [ADDRESS_WIDTH-1:0] r_word_cnt;
  logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_data_valid;

  logic                     w_prog_mode;
  logic                     w_start;
  logic                     w_accept;
  logic                     w_last_bit;
  logic                     w_last_word;
  logic                     w_mem_we;
  logic [DATA_WIDTH-1:0]    w_word;

  assign w_prog_mode = (mode == c_MODE_PROG);
  assign w_start     = w_prog_mode && load_start;
  assign w_accept    = ser_valid && ser_ready;
  assign w_last_bit  = (r_bit_cnt == c_CNT_W'(c_BITS - 1));
  assign w_last_word = (r_word_cnt == {ADDRESS_WIDTH{1'b1}});
  // Data bits sit above the parity bit when parity is enabled.
  assign w_word      = r_shift[c_BITS-1 -: DATA_WIDTH];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    if (!w_prog_mode) begin
      w_state_nxt = c_ST_IDLE;
    end else if (load_start) begin
      w_state_nxt = c_ST_SHIFT;
    end else begin
      case (r_state)
        c_ST_SHIFT: if (w_accept && w_last_bit) w_state_nxt = c_ST_WRITE;
        c_ST_WRITE: w_state_nxt = w_last_word ? c_ST_DONE : c_ST_SHIFT;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ser_ready = (r_state == c_ST_SHIFT);
    prog_busy = (r_state == c_ST_SHIFT) || (r_state == c_ST_WRITE);
    prog_done = (r_state == c_ST_DONE);
    // A completed word is dropped if the load is aborted in its write cycle.
    w_mem_we  = (r_state == c_ST_WRITE) && w_prog_mode && !load_start && !rst;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (!w_prog_mode) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_shift   <= {r_shift[c_BITS-2:0], ser_in};
        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
      end
      if (w_mem_we) begin
        r_word_cnt <= r_word_cnt + ADDRESS_WIDTH'(1);
        r_bit_cnt  <= '0;
      end
    end
  end

  assign word_count = r_word_cnt;

  // Program memory: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_word_cnt] <= w_word;
    end
  end

  // ---------------------------------------------------------------- fetch port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else if (mode == c_MODE_RUN) begin
      r_data_out   <= r_mem[address];
      r_data_valid <= 1'b1;
    end else begin
      r_data_valid <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

  // ---------------------------------------------------------------- parity
`ifdef PM_LOADER_PARITY_EN
  logic r_parity_err;

  // Even parity: data plus parity bit must XOR to zero.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_parity_err <= 1'b0;
    end else if (w_mem_we && (^r_shift)) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pm_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pm_serial_loader
// Brief    : Randomized self-checking bench for pm_serial_loader.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 4
`endif
`ifndef INSTR_WORD_WIDTH
`define INSTR_WORD_WIDTH 16
`endif
`ifndef MODE_RUN
`define MODE_RUN 2'b01
`endif
`ifndef MODE_PROG_PM
`define MODE_PROG_PM 2'b10
`endif

module tb_pm_serial_loader;

  localparam int AW    = `ADDRESS_WIDTH;
  localparam int DW    = `INSTR_WORD_WIDTH;
  localparam int DEPTH = 2 ** AW;
`ifdef PM_LOADER_PARITY_EN
  localparam int BITS  = DW + 1;
`else
  localparam int BITS  = DW;
`endif

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic          load_start;
  logic          ser_in;
  logic          ser_valid;
  logic          ser_ready;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          prog_busy;
  logic          prog_done;
  logic [AW-1:0] word_count;
  logic          parity_err;

  pm_serial_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .load_start(load_start),
    .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .address(address), .data_out(data_out), .data_valid(data_valid),
    .prog_busy(prog_busy), .prog_done(prog_done),
    .word_count(word_count), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image plus load bookkeeping.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  int            exp_wc;
  bit            exp_done;
  bit            exp_perr;
  bit            phase;
  int            n_tests;
  int            n_fail;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    mode       = `MODE_PROG_PM;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    exp_wc   = 0;
    exp_done = 1'b0;
    exp_perr = 1'b0;
    check_val("start_busy", prog_busy, 1);
    check_val("start_wc", word_count, 0);
    check_val("start_done", prog_done, 0);
    check_val("start_perr", parity_err, 0);
  endtask

  // Offers nbits bits MSB first; with toggle, ser_valid alternates and idle bits are noise.
  task automatic send_bits(input logic [BITS-1:0] bv, input int nbits, input bit toggle);
    int i    = BITS - 1;
    int sent = 0;
    while (sent < nbits) begin
      ser_valid = toggle ? phase : 1'b1;
      phase     = ~phase;
      ser_in    = ser_valid ? bv[i] : 1'($urandom);
      check_val("shift_ready", ser_ready, 1);
      step();
      if (ser_valid) begin
        i--;
        sent++;
      end
    end
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] word, input bit flip, input bit toggle);
    logic [BITS-1:0] bv;
`ifdef PM_LOADER_PARITY_EN
    bv = {word, (^word) ^ flip};
`else
    bv = word;
`endif
    send_bits(bv, BITS, toggle);
    // Write cycle: a bit offered here must not be consumed.
    ser_valid = 1'b1;
    ser_in    = 1'($urandom);
    check_val("write_ready", ser_ready, 0);
    check_val("write_busy", prog_busy, 1);
    step();
    ser_valid = 1'b0;
    ref_mem[exp_wc] = word;
    known[exp_wc]   = 1'b1;
    exp_wc = (exp_wc + 1) % DEPTH;
    if (exp_wc == 0) exp_done = 1'b1;
`ifdef PM_LOADER_PARITY_EN
    if (flip) exp_perr = 1'b1;
`endif
    check_val("word_count", word_count, exp_wc);
    check_val("prog_done", prog_done, exp_done);
    check_val("parity_err", parity_err, exp_perr);
  endtask

  task automatic read_word(input int a);
    mode    = `MODE_RUN;
    address = AW'(a);
    step();
    check_val("rd_valid", data_valid, 1);
    if (known[a]) check_val($sformatf("rd_data[%0d]", a), data_out, ref_mem[a]);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; phase = 1'b0;
    exp_wc = 0; exp_done = 1'b0; exp_perr = 1'b0;
    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
    rst = 1'b1; mode = 2'b00; load_start = 1'b0;
    ser_in = 1'b0; ser_valid = 1'b0; address = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check_val("rst_data_out", data_out, 0);
    check_val("rst_data_valid", data_valid, 0);
    check_val("rst_ready", ser_ready, 0);
    check_val("rst_busy", prog_busy, 0);
    check_val("rst_done", prog_done, 0);
    check_val("rst_wc", word_count, 0);
    check_val("rst_perr", parity_err, 0);

    // Full load of 0,1,2,... then fetch address 5
    start_load();
    for (int k = 0; k < DEPTH; k++) send_word(DW'(k), 1'b0, 1'b0);
    check_val("full_busy", prog_busy, 0);
    check_val("full_ready", ser_ready, 0);
    repeat (3) step();
    check_val("done_sticky", prog_done, 1);
    check_val("done_wc", word_count, 0);
    read_word(5);
    check_val("run_done_clr", prog_done, 0);

    // Non-run modes hold data_out and drop data_valid
    mode = 2'b11; address = AW'(9);
    step();
    check_val("hold_valid", data_valid, 0);
    check_val("hold_data", data_out, ref_mem[5]);
    mode = `MODE_PROG_PM;
    step();
    check_val("prog_no_start_busy", prog_busy, 0);
    check_val("prog_hold_data", data_out, ref_mem[5]);

    // load_start ignored outside program mode
    mode = `MODE_RUN; load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_val("ign_start_busy", prog_busy, 0);

    // Toggled ser_valid load, then restart straight from DONE
    start_load();
    for (int k = 0; k < DEPTH; k++) send_word(DW'($urandom), 1'b0, 1'b1);
    start_load();
    for (int k = 0; k < DEPTH; k++) send_word(DW'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) read_word(k);
    for (int k = 0; k < 8; k++) read_word(int'($urandom_range(DEPTH - 1)));

    // Mode exit after 3.5 words: words 0..2 new, word 3 unchanged
    start_load();
    for (int k = 0; k < 3; k++) send_word(DW'($urandom), 1'b0, 1'b0);
    send_bits(BITS'($urandom), BITS / 2, 1'b0);
    mode = `MODE_RUN; address = '0;
    step();
    check_val("exit_busy", prog_busy, 0);
    check_val("exit_ready", ser_ready, 0);
    check_val("exit_done", prog_done, 0);
    check_val("exit_rd_data[0]", data_out, ref_mem[0]);
    for (int k = 1; k < 4; k++) read_word(k);

    // load_start mid-load restarts at word 0
    start_load();
    for (int k = 0; k < 2; k++) send_word(DW'($urandom), 1'b0, 1'b0);
    send_bits(BITS'($urandom), BITS / 2, 1'b0);
    start_load();
    send_word(DW'($urandom) | DW'(1), 1'b1, 1'b0);
    send_bits(BITS'($urandom), BITS / 2, 1'b0);

    // rst mid-word wins over load_start
    rst = 1'b1; load_start = 1'b1;
    step();
    rst = 1'b0; load_start = 1'b0;
    exp_wc = 0; exp_done = 1'b0; exp_perr = 1'b0;
    check_val("mid_rst_busy", prog_busy, 0);
    check_val("mid_rst_ready", ser_ready, 0);
    check_val("mid_rst_wc", word_count, 0);
    check_val("mid_rst_perr", parity_err, 0);
    check_val("mid_rst_data", data_out, 0);
    check_val("mid_rst_valid", data_valid, 0);
    start_load();
    for (int k = 0; k < 2; k++) send_word(DW'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) read_word(k);

`ifdef PM_LOADER_PARITY_EN
    // Bad parity flags the load but the word is still stored
    start_load();
    send_word(DW'($urandom) | DW'(1), 1'b1, 1'b0);
    send_word(DW'($urandom), 1'b0, 1'b0);
    check_val("perr_sticky", parity_err, 1);
    read_word(0);
    read_word(1);
    start_load();
    send_word(DW'($urandom), 1'b0, 1'b0);
    read_word(0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
